// File: rtl/map_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : map_arb_pkg
//  Purpose  : Shared constants for the tile-map BRAM port arbiter: read-return
//             tag encoding, requester indices and the default BRAM latency.
//  Revision : 1.0  initial release
// ============================================================================
package map_arb_pkg;

   // Tag carried alongside each BRAM access so returned data can be routed.
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_R    = 2'd1;
   localparam logic [1:0] TAG_P    = 2'd2;

   // Bit positions in the three-way grant vector.
   localparam int REQ_R = 0;
   localparam int REQ_P = 1;
   localparam int REQ_W = 2;

   // Bit positions inside the player/write round-robin slot.
   localparam int SLOT_P = 0;
   localparam int SLOT_W = 1;

   localparam int MEM_LAT_DEFAULT = 1;

endpackage
`default_nettype wire

// File: rtl/map_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : map_arb_rr2
//  Purpose  : Two-way round-robin picker for the player/write slot.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             req[1:0]      - requests, index SLOT_P / SLOT_W
//             accept        - slot actually won arbitration this cycle
//             gnt[1:0]      - one-hot pick (valid only when accept is high)
//  Revision : 1.0  initial release
// ============================================================================
module map_arb_rr2
   import map_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // 1 = write was the last one granted, 0 = player was.
   logic last_w_q, last_w_d;

   always_comb begin
      gnt      = 2'b00;
      last_w_d = last_w_q;
      if (req[SLOT_P] && req[SLOT_W]) begin
         if (last_w_q) gnt[SLOT_P] = 1'b1;
         else          gnt[SLOT_W] = 1'b1;
      end else begin
         gnt = req;
      end
      // Pointer only moves when the slot really transferred.
      if (accept && (|req)) last_w_d = gnt[SLOT_W];
   end

   always_ff @(posedge clk) begin
      if (rst) last_w_q <= 1'b1;   // player wins the first tie after reset
      else     last_w_q <= last_w_d;
   end

endmodule
`default_nettype wire

// File: rtl/map_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : map_port_arbiter
//  Purpose  : Shares one tile-map BRAM port between the renderer (r), the
//             player block (p, reads) and game logic (w, writes). Renderer has
//             fixed priority, limited by a starvation guard; p/w share a
//             round-robin slot. Read data is routed back via a tag pipeline.
//  Ports    : r_req/r_addr/r_gnt/r_rvalid  - renderer read port
//             p_req/p_addr/p_gnt/p_rvalid  - player read port
//             w_req/w_addr/w_data/w_gnt    - game-logic write port
//             rdata                        - shared read data (pass-through)
//             mem_addr/mem_we/mem_din      - registered BRAM command
//             mem_dout                     - BRAM read data
//             starve_cnt                   - saturating guard-activation count
//  Revision : 1.0  initial release
// ============================================================================
module map_port_arbiter
   import map_arb_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int MEM_LAT    = MEM_LAT_DEFAULT,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              r_gnt,
   output logic              r_rvalid,
   input  logic              p_req,
   input  logic [ADDR_W-1:0] p_addr,
   output logic              p_gnt,
   output logic              p_rvalid,
   input  logic              w_req,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_gnt,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [15:0]       starve_cnt
);

   localparam int                 GUARD_W = $clog2(STARVE_MAX + 1);
   localparam logic [GUARD_W-1:0] GUARD_TOP = GUARD_W'(STARVE_MAX);

   logic [GUARD_W-1:0]          guard_q, guard_d;
   logic [15:0]                 starve_q, starve_d;
   logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]           mem_din_q, mem_din_d;
   logic                        mem_we_q, mem_we_d;
   logic [1:0]                  tag_issue_q, tag_issue_d;
   logic [MEM_LAT-1:0][1:0]     tag_pipe_q, tag_pipe_d;

   logic       pw_req;
   logic       guard_fire;
   logic       r_win;
   logic       slot_en;
   logic [1:0] rr_req;
   logic [1:0] rr_gnt;
   logic [2:0] gnt_vec;

   // ---------------------------------------------------------------- grant
   assign rr_req[SLOT_P] = p_req;
   assign rr_req[SLOT_W] = w_req;

   map_arb_rr2 u_rr2 (
      .clk    (clk),
      .rst    (rst),
      .req    (rr_req),
      .accept (slot_en),
      .gnt    (rr_gnt)
   );

   always_comb begin
      pw_req     = p_req | w_req;
      // Guard blocks the renderer once it has won STARVE_MAX times in a row
      // while the p/w slot was waiting.
      guard_fire = !rst && pw_req && (guard_q == GUARD_TOP);
      r_win      = !rst && r_req && !guard_fire;
      slot_en    = !rst && !r_win;
      gnt_vec         = 3'b000;
      gnt_vec[REQ_R]  = r_win;
      gnt_vec[REQ_P]  = slot_en & rr_gnt[SLOT_P];
      gnt_vec[REQ_W]  = slot_en & rr_gnt[SLOT_W];
   end

   assign r_gnt = gnt_vec[REQ_R];
   assign p_gnt = gnt_vec[REQ_P];
   assign w_gnt = gnt_vec[REQ_W];

   // ----------------------------------------------------- guard / counters
   always_comb begin
      guard_d = guard_q;
      if (gnt_vec[REQ_R] && pw_req)                       guard_d = guard_q + 1'b1;
      else if (gnt_vec[REQ_P] || gnt_vec[REQ_W] || !pw_req) guard_d = '0;

      starve_d = starve_q;
      if (guard_fire && (starve_q != 16'hFFFF)) starve_d = starve_q + 16'd1;
   end

   // ---------------------------------------------------------- memory issue
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      mem_we_d    = 1'b0;
      tag_issue_d = TAG_NONE;
      if (gnt_vec[REQ_R]) begin
         mem_addr_d  = r_addr;
         tag_issue_d = TAG_R;
      end else if (gnt_vec[REQ_P]) begin
         mem_addr_d  = p_addr;
         tag_issue_d = TAG_P;
      end else if (gnt_vec[REQ_W]) begin
         mem_addr_d  = w_addr;
         mem_din_d   = w_data;
         mem_we_d    = 1'b1;
      end
   end

   // Tag issued with the BRAM command, then delayed MEM_LAT cycles so it lines
   // up with mem_dout.
   always_comb begin
      tag_pipe_d    = tag_pipe_q;
      tag_pipe_d[0] = tag_issue_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         tag_pipe_d[i] = tag_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         guard_q     <= '0;
         starve_q    <= '0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_we_q    <= 1'b0;
         tag_issue_q <= TAG_NONE;
         tag_pipe_q  <= '0;
      end else begin
         guard_q     <= guard_d;
         starve_q    <= starve_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_we_q    <= mem_we_d;
         tag_issue_q <= tag_issue_d;
         tag_pipe_q  <= tag_pipe_d;
      end
   end

   // --------------------------------------------------------------- outputs
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_we     = mem_we_q;
   assign starve_cnt = starve_q;
   assign rdata      = mem_dout;
   // Gated by rst so a read returning during the reset cycle is dropped too.
   assign r_rvalid   = !rst && (tag_pipe_q[MEM_LAT-1] == TAG_R);
   assign p_rvalid   = !rst && (tag_pipe_q[MEM_LAT-1] == TAG_P);

endmodule
`default_nettype wire

// File: doc/map_port_arbiter.md
# map_port_arbiter

Shares the single read/write port of the tile-map block RAM between three requesters: the map renderer (streaming tile reads), the player block (collision/tile lookups) and game logic (tile writes, e.g. item pickup or door opening). Fixed priority favours the renderer, with a starvation guard so lookups and writes always complete. It sits between those three clients and one `bRAM_map` port and tags each access so the returned read data reaches the requester that issued it.

## Interface
- `ADDR_W`, 19, map address width
- `DATA_W`, 16, tile word width
- `MEM_LAT`, 1, BRAM read latency in cycles (1..3)
- `STARVE_MAX`, 8, maximum consecutive renderer grants while another requester is pending
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `r_req` / `p_req`  in  1  read request from renderer / player
- `r_addr` / `p_addr`  in  ADDR_W  read address
- `r_gnt` / `p_gnt`  out  1  grant (combinational)
- `r_rvalid` / `p_rvalid`  out  1  read data valid
- `w_req`  in  1  write request from game logic
- `w_addr`  in  ADDR_W  write address
- `w_data`  in  DATA_W  write data
- `w_gnt`  out  1  write grant (combinational)
- `rdata`  out  DATA_W  read data shared by all requesters; qualify it with the requester's `*_rvalid`
- `mem_addr`  out  ADDR_W  BRAM address (registered)
- `mem_we`  out  1  BRAM write enable (registered)
- `mem_din`  out  DATA_W  BRAM write data (registered)
- `mem_dout`  in  DATA_W  BRAM read data
- `starve_cnt`  out  16  count of starvation-guard activations; saturates at 0xFFFF

## Operation
- Handshake:
  - A transfer occurs at a rising edge where `x_req && x_gnt`.
  - A requester holds `req` and its address/data stable until that edge.
  - `req` can stay high for back-to-back transfers; one transfer per cycle in total.
  - `gnt` depends on `req` inputs and internal state only, never on `*_gnt`.
- At most one `*_gnt` is high per cycle. Winner selection:
  1. If `guard_cnt == STARVE_MAX` and `p_req || w_req`: the renderer is blocked and the player/write slot is granted.
  2. Else if `r_req`: grant the renderer.
  3. Else: grant the player/write slot.
- Player/write slot: round-robin between `p` and `w`.
  - Pointer `rr_last` records the last of the two granted.
  - If both are requesting, grant the one not equal to `rr_last`.
  - If only one is requesting, grant it.
- Guard counter `guard_cnt` (0..STARVE_MAX):
  - Increments when `r` is granted while `p_req || w_req`.
  - Clears when `p` or `w` is granted, or when neither `p_req` nor `w_req` is high.
  - `starve_cnt` increments on every cycle that rule 1 fires.
- Memory issue:
  - On transfer, the next edge registers `mem_addr`, `mem_din` and `mem_we` (`mem_we` = 1 only for a `w` transfer).
  - With no transfer: `mem_we` = 0; `mem_addr` and `mem_din` hold their values.
- Read return:
  - A `MEM_LAT`-deep shift register carries a 2-bit tag (none/r/p).
  - `rdata` = `mem_dout`, combinational pass-through.
  - `x_rvalid` is high in exactly one cycle per granted read.
- Ordering: memory sees accesses in grant order, so a write granted before a read to the same address is visible to that read (BRAM port configured READ_FIRST, one access per cycle).

## Timing
- Read granted at edge E (cycle C):
  - `mem_addr` is valid in cycle C+1.
  - `x_rvalid` and `rdata` are valid in cycle C+1+MEM_LAT (C+2 for the default).
- Write granted in cycle C: BRAM write occurs at the edge ending cycle C+1.
- Throughput: 1 access per cycle. Reads from different requesters pipeline without bubbles.
- Reset (sync, active-high):
  - All `*_gnt` forced to 0 while `rst` is high.
  - `mem_addr` = 0, `mem_we` = 0, `mem_din` = 0, all `*_rvalid` = 0.
  - Tag pipeline cleared, `guard_cnt` = 0, `rr_last` = w (so `p` wins the first tie), `starve_cnt` = 0.
- Reset mid-operation: in-flight reads are dropped. No `rvalid` is produced after the reset edge for reads issued before it.
- Simultaneous `p_req` and `w_req` with `r_req` low: round-robin alternates `p`, `w`, `p`, … every cycle.
- `STARVE_MAX` boundary: with `r_req` held high and a pending `p`/`w`, the renderer receives exactly `STARVE_MAX` grants, then one `p`/`w` grant, then the renderer again.

## Structure
- Shared package `map_arb_pkg`:
  - tag encoding constants `TAG_NONE`, `TAG_R`, `TAG_P`
  - requester index constants
  - default `MEM_LAT`
- Sub-module `map_arb_rr2`: the two-way round-robin picker between `p` and `w` (`req[1:0]` → `gnt[1:0]`, pointer update on accept). Everything else is implemented in `map_port_arbiter`.

## Test plan
- Reset: with `rst` high, `r_req = p_req = w_req = 1` → all `gnt` = 0, `mem_we` = 0, `rvalid` = 0. First cycle after reset release: `r_gnt` = 1.
- Single read: `p_req` with `p_addr = 0x00023`, BRAM preloaded with 0x0102 → `p_gnt` in the same cycle, `mem_addr = 0x00023` at C+1, `p_rvalid = 1` and `rdata = 0x0102` at C+2, `r_rvalid` stays 0.
- Write then read: `w` writes 0x00AA to address 5 in cycle C; `p` reads address 5 in cycle C+1 → `p_rvalid` at C+3 with `rdata = 0x00AA`.
- Starvation guard: `r_req` held high, `p_req` raised at cycle 0 → `r_gnt` for cycles 0..7, `p_gnt` at cycle 8, `starve_cnt = 1`, then `r_gnt` again from cycle 9.
- Round-robin: `p_req = w_req = 1`, `r_req = 0` for 6 cycles → grants p, w, p, w, p, w; `mem_we` pattern at C+1 is 0, 1, 0, 1, 0, 1.
- Reset mid-read: reads by `r` and `p` granted back-to-back, `rst` asserted the next cycle → neither `rvalid` ever asserts; a fresh `r` read after reset returns correct data at C+2.
